// File: rtl/countdown_timer.sv
// HH:MM:SS BCD countdown timer with internal one-second prescaler.
// Digit outputs keep the up-counter's order so the existing scan driver can show them unchanged.
module countdown_timer #(
  parameter int CLK_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ld_h1,
  input  logic [3:0] ld_h0,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_m0,
  input  logic [3:0] ld_s1,
  input  logic [3:0] ld_s0,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] out_h1,
  output logic [3:0] out_h0,
  output logic [3:0] out_m1,
  output logic [3:0] out_m0,
  output logic [3:0] out_s1,
  output logic [3:0] out_s0,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [23:0]   r_val, w_val_nxt, w_val_dec, w_val_ld;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_running, r_done, r_alarm;
  logic          w_running_nxt, w_done_nxt, w_alarm_nxt;
  logic          w_load_ok, w_tick, w_nonzero, w_expire;

  function automatic logic [3:0] f_clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Digit i (0 = s0 .. 5 = h1); odd digits below hours are tens of min/sec and wrap to 5.
  function automatic logic [23:0] f_bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = ((i % 2 == 1) && (i < 5)) ? 4'd5 : 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_nonzero = |r_val;
  assign w_load_ok = load && (r_state != S_RUN);
  assign w_tick    = !clear && (r_state == S_RUN) && !pause && (r_presc == PRESC_MAX);
  assign w_val_dec = f_bcd_dec(r_val);
  assign w_expire  = w_tick && (w_val_dec == 24'd0);
  assign w_val_ld  = {f_clamp(ld_h1, 4'd9), f_clamp(ld_h0, 4'd9),
                      f_clamp(ld_m1, 4'd5), f_clamp(ld_m0, 4'd9),
                      f_clamp(ld_s1, 4'd5), f_clamp(ld_s0, 4'd9)};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: clear > load > start/pause > tick
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else if (w_load_ok) begin
      w_state_nxt = (r_state == S_PAUSE) ? S_PAUSE : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start && w_nonzero) w_state_nxt = S_RUN;
        S_PAUSE: if (start && w_nonzero) w_state_nxt = S_RUN;
        S_RUN: begin
          if (pause)         w_state_nxt = S_PAUSE;
          else if (w_expire) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output / datapath next values; pause freezes the prescaler so a resume finishes the partial second
  always_comb begin
    w_val_nxt     = r_val;
    w_presc_nxt   = r_presc;
    w_alarm_nxt   = r_alarm;
    w_done_nxt    = w_expire;
    w_running_nxt = (w_state_nxt == S_RUN);
    if (clear) begin
      w_val_nxt   = 24'd0;
      w_presc_nxt = '0;
      w_alarm_nxt = 1'b0;
    end else if (w_load_ok) begin
      w_val_nxt   = w_val_ld;
      w_presc_nxt = '0;
      w_alarm_nxt = 1'b0;
    end else if ((r_state == S_RUN) && !pause) begin
      if (w_tick) begin
        w_val_nxt   = w_val_dec;
        w_presc_nxt = '0;
        if (w_expire) w_alarm_nxt = 1'b1;
      end else begin
        w_presc_nxt = r_presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val     <= 24'd0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_val     <= w_val_nxt;
      r_presc   <= w_presc_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
      r_alarm   <= w_alarm_nxt;
    end
  end

  assign out_h1  = r_val[23:20];
  assign out_h0  = r_val[19:16];
  assign out_m1  = r_val[15:12];
  assign out_m0  = r_val[11:8];
  assign out_s1  = r_val[7:4];
  assign out_s0  = r_val[3:0];
  assign running = r_running;
  assign done    = r_done;
  assign alarm   = r_alarm;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown counterpart to the free-running HH:MM:SS up-counter.
- Loads a BCD preset, decrements once per second, and flags expiry with a one-cycle `done` pulse and a latched `alarm` level.
- The six BCD digit outputs use the same digit order as the up-counter, so the existing 8-digit scan/7-segment driver can display them unchanged.
- Has an internal prescaler; no external divided clock.

Parameters:
- CLK_PER_SEC, 100000000: clk cycles per one-second decrement; must be ≥ 2. Benches use 4.

Ports:
- clk     input   1  system clock; the only clock.
- rst_n   input   1  synchronous active-low reset, sampled on rising clk.
- load    input   1  one-cycle request to load the preset digits.
- ld_h1   input   4  preset, hours tens (BCD).
- ld_h0   input   4  preset, hours units.
- ld_m1   input   4  preset, minutes tens.
- ld_m0   input   4  preset, minutes units.
- ld_s1   input   4  preset, seconds tens.
- ld_s0   input   4  preset, seconds units.
- start   input   1  begin or resume counting.
- pause   input   1  suspend counting.
- clear   input   1  abort; zero all digits; go to IDLE.
- out_h1, out_h0, out_m1, out_m0, out_s1, out_s0   output   4 each  current BCD value, registered.
- running  output  1  high while in RUN.
- done     output  1  one-cycle pulse on expiry.
- alarm    output  1  latched expiry flag.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE; all digits = 0; prescaler = 0.
  - running = 0, done = 0, alarm = 0.
  - Applies from any state, including mid-RUN.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- Command priority, evaluated each cycle: clear > load > start/pause > tick.
- clear (any state):
  - All digits = 0; state = IDLE; alarm = 0; prescaler = 0.
- load (accepted in IDLE, PAUSE, DONE; ignored in RUN):
  - Each digit is clamped before it is stored:
    - units digits > 9 → 9;
    - ld_m1 and ld_s1 > 5 → 5;
    - ld_h1 > 9 → 9.
  - Hours range is 00–99.
  - alarm = 0; prescaler = 0.
  - Next state: IDLE, except PAUSE stays PAUSE.
- start:
  - IDLE → RUN or PAUSE → RUN, only if the value is nonzero.
  - start with value 00:00:00 is ignored.
  - start in RUN or DONE has no effect.
- pause:
  - RUN → PAUSE.
  - The prescaler count is frozen, not cleared, so resuming completes the partial second.
  - Ignored in other states.
- start and pause in the same cycle: each is only considered in its own source state, so no conflict exists.
- Prescaler:
  - Counts 0..CLK_PER_SEC-1 only in RUN.
  - tick = RUN and prescaler == CLK_PER_SEC-1; the prescaler wraps to 0 on tick.
  - The first decrement occurs exactly CLK_PER_SEC cycles after the cycle in which start is sampled.
- Decrement on tick (BCD borrow chain):
  - s0: 9..0; borrow → 9.
  - s1: 5..0; borrow → 5.
  - m0: 9..0; borrow → 9.
  - m1: 5..0; borrow → 5.
  - h0: 9..0; borrow → 9.
  - h1: 9..0.
  - Example: 01:00:00 → 00:59:59.
- Expiry:
  - The tick that produces 00:00:00 registers the zero digits, moves state to DONE, asserts done for exactly that following cycle, and sets alarm = 1.
  - The value never wraps below zero.
- DONE:
  - Digits hold 00:00:00; alarm holds until clear, load, or reset.
  - start is ignored until a nonzero load.
- running = (state == RUN), registered alongside state.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset, then load 00:00:03, start, CLK_PER_SEC=4:
  - value reads 00:00:02 after 4 cycles, 00:00:01 after 8, 00:00:00 after 12;
  - done high for exactly 1 cycle; alarm stays 1; running = 0.
- Borrow chain: load 10:00:00, start, run 1 tick → 09:59:59; load 00:01:00, start, 1 tick → 00:00:59.
- Clamping: load with ld_s1=7, ld_s0=12, ld_m1=9, ld_h1=15 → reads 99:5x:59-style clamped digits (h1=9, m1=5, s1=5, s0=9).
- Pause/resume:
  - load 00:00:05, start, pause after 2 cycles;
  - hold paused 20 cycles → value unchanged at 00:00:05;
  - start → first decrement after 2 more cycles.
- Priority and ignores:
  - start with 00:00:00 → stays IDLE;
  - load during RUN → ignored;
  - clear + load in the same cycle → digits 0, IDLE;
  - after DONE, start alone → no change; load 00:00:01 then start → counts.
- Reset mid-RUN (value 00:30:00) → next cycle all digits 0, state IDLE, alarm 0, running 0; held low for 3 cycles, outputs stay reset.
